// File: rtl/ctrl_unit_seq.sv
// Instruction-decode control unit: opcode -> registered control word,
// two-word IADD, halt/resume, stall/flush. Illegal trap: CTRL_ILLEGAL_TRAP_EN.
module ctrl_unit_seq #(
  parameter int WORD_W = 16,
  parameter int OPC_W  = 7,
  parameter int SIG_W  = 23,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] instr_word,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              resume,
  output logic [SIG_W-1:0]  sig_out,
  output logic              sig_valid,
  output logic [WORD_W-1:0] imm_out,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {RUN, IMM, HALT} state_t;

  localparam logic [6:0] OP_NOT  = 7'b0010001;
  localparam logic [6:0] OP_INC  = 7'b0000011;
  localparam logic [6:0] OP_OUT  = 7'b0011001;
  localparam logic [6:0] OP_IN   = 7'b0011000;
  localparam logic [6:0] OP_HLT  = 7'b1100001;
  localparam logic [6:0] OP_NOP  = 7'b1101000;
  localparam logic [6:0] OP_SETC = 7'b1100010;
  localparam logic [6:0] OP_MOV  = 7'b0010101;
  localparam logic [6:0] OP_ADD  = 7'b0001101;
  localparam logic [6:0] OP_SUB  = 7'b0001001;
  localparam logic [6:0] OP_AND  = 7'b0001111;
  localparam logic [6:0] OP_IADD = 7'b0100000;

  localparam logic [22:0] S_NOT  = 23'b01110111000001001100011;
  localparam logic [22:0] S_INC  = 23'b01110110000000001100011;
  localparam logic [22:0] S_OUT  = 23'b01100111000001011100011;
  localparam logic [22:0] S_IN   = 23'b01111111000001011100011;
  localparam logic [22:0] S_HLT  = 23'b00000011000001110000001;
  localparam logic [22:0] S_NOP  = 23'b01100111000001110100001;
  localparam logic [22:0] S_SETC = 23'b01100111000000011100011;
  localparam logic [22:0] S_MOV  = 23'b01110111000001011100011;
  localparam logic [22:0] S_ADD  = 23'b01110111000000001100011;
  localparam logic [22:0] S_SUB  = 23'b01110111000000101100011;
  localparam logic [22:0] S_AND  = 23'b01110111000000111100011;
  localparam logic [22:0] S_IADD = 23'b10110111100000001100011;

  localparam logic [OPC_W-1:0] LOW_MASK = OPC_W'(7'h7F);

  state_t           state;
  logic [OPC_W-1:0] opc;
  logic [6:0]       op7;
  logic             hi_zero;
  logic [22:0]      dsig;
  logic             legal;
  logic             is_hlt;
  logic             is_iadd;
  logic             accept;

  assign opc      = instr_word[WORD_W-1 -: OPC_W];
  assign op7      = opc[6:0];
  assign hi_zero  = (opc & ~LOW_MASK) == '0;
  assign in_ready = !stall && !flush && (state != HALT);
  assign accept   = in_valid && in_ready;
  assign halted   = (state == HALT);
  assign is_hlt   = legal && (op7 == OP_HLT);
  assign is_iadd  = legal && (op7 == OP_IADD);

  // Unknown or over-wide opcodes fall back to the NOP word.
  always_comb begin
    dsig  = S_NOP;
    legal = 1'b1;
    unique case (1'b1)
      (op7 == OP_NOT):  dsig = S_NOT;
      (op7 == OP_INC):  dsig = S_INC;
      (op7 == OP_OUT):  dsig = S_OUT;
      (op7 == OP_IN):   dsig = S_IN;
      (op7 == OP_HLT):  dsig = S_HLT;
      (op7 == OP_NOP):  dsig = S_NOP;
      (op7 == OP_SETC): dsig = S_SETC;
      (op7 == OP_MOV):  dsig = S_MOV;
      (op7 == OP_ADD):  dsig = S_ADD;
      (op7 == OP_SUB):  dsig = S_SUB;
      (op7 == OP_AND):  dsig = S_AND;
      (op7 == OP_IADD): dsig = S_IADD;
      default:          legal = 1'b0;
    endcase
    if (!hi_zero) begin
      dsig  = S_NOP;
      legal = 1'b0;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_q;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      sig_out   <= '0;
      sig_valid <= 1'b0;
      imm_out   <= '0;
      retired   <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ill_q     <= 1'b0;
`endif
    end else if (flush) begin
      state     <= RUN;
      sig_valid <= 1'b0;
      sig_out   <= SIG_W'(S_NOP);
    end else if (!stall) begin
      if (sig_valid) retired <= retired + CNT_W'(1);
      sig_valid <= 1'b0;
      sig_out   <= SIG_W'(S_NOP);
      unique case (state)
        RUN: if (accept) begin
          if (is_iadd) begin
            state <= IMM;
          end else begin
            sig_valid <= 1'b1;
            sig_out   <= SIG_W'(dsig);
            if (is_hlt) state <= HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (!legal) begin
              ill_q <= 1'b1;
              state <= HALT;
            end
`endif
          end
        end
        IMM: if (accept) begin
          imm_out   <= instr_word;
          sig_out   <= SIG_W'(S_IADD);
          sig_valid <= 1'b1;
          state     <= RUN;
        end
        HALT: if (resume) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Bench for ctrl_unit_seq: decode table vectors plus scoreboarded
// sequences for IMM, HALT, flush, stall, illegal and counter wrap.
module tb_ctrl_unit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_word;
  logic        in_valid;
  logic        in_ready;
  logic        stall;
  logic        flush;
  logic        resume;
  logic [22:0] sig_out;
  logic        sig_valid;
  logic [15:0] imm_out;
  logic        halted;
  logic        illegal;
  logic [3:0]  retired;

  always #5 clk = ~clk;

  ctrl_unit_seq #(
    .WORD_W(16), .OPC_W(7), .SIG_W(23), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .instr_word(instr_word),
    .in_valid(in_valid), .in_ready(in_ready), .stall(stall),
    .flush(flush), .resume(resume), .sig_out(sig_out),
    .sig_valid(sig_valid), .imm_out(imm_out), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [6:0] OP_NOT  = 7'b0010001;
  localparam logic [6:0] OP_INC  = 7'b0000011;
  localparam logic [6:0] OP_OUT  = 7'b0011001;
  localparam logic [6:0] OP_IN   = 7'b0011000;
  localparam logic [6:0] OP_HLT  = 7'b1100001;
  localparam logic [6:0] OP_NOP  = 7'b1101000;
  localparam logic [6:0] OP_SETC = 7'b1100010;
  localparam logic [6:0] OP_MOV  = 7'b0010101;
  localparam logic [6:0] OP_ADD  = 7'b0001101;
  localparam logic [6:0] OP_SUB  = 7'b0001001;
  localparam logic [6:0] OP_AND  = 7'b0001111;
  localparam logic [6:0] OP_IADD = 7'b0100000;

  localparam logic [22:0] S_NOT  = 23'b01110111000001001100011;
  localparam logic [22:0] S_INC  = 23'b01110110000000001100011;
  localparam logic [22:0] S_OUT  = 23'b01100111000001011100011;
  localparam logic [22:0] S_IN   = 23'b01111111000001011100011;
  localparam logic [22:0] S_HLT  = 23'b00000011000001110000001;
  localparam logic [22:0] S_NOP  = 23'b01100111000001110100001;
  localparam logic [22:0] S_SETC = 23'b01100111000000011100011;
  localparam logic [22:0] S_MOV  = 23'b01110111000001011100011;
  localparam logic [22:0] S_ADD  = 23'b01110111000000001100011;
  localparam logic [22:0] S_SUB  = 23'b01110111000000101100011;
  localparam logic [22:0] S_AND  = 23'b01110111000000111100011;
  localparam logic [22:0] S_IADD = 23'b10110111100000001100011;

  typedef struct {
    logic [22:0] sig;
    logic        vld;
    logic [15:0] imm;
    logic        hlt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [22:0] sig;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       cur;
  vec_t       vt[10];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] mret;
  logic       prev_vld;
  logic       m_ill;
  logic       saw_wrap;

  function automatic exp_t mk(input logic [22:0] s, input logic v,
                              input logic [15:0] i, input logic h,
                              input logic il);
    exp_t e;
    e.sig = s; e.vld = v; e.imm = i; e.hlt = h; e.ill = il;
    return e;
  endfunction

  function automatic logic [15:0] ow(input logic [6:0] op);
    return {op, 9'h1A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic apply(input logic [15:0] w, input logic v,
                       input logic s, input logic f, input logic r,
                       input logic rdy, input exp_t e);
    exp_t got;
    @(negedge clk);
    instr_word = w; in_valid = v; stall = s; flush = f; resume = r;
    #1 chk("in_ready", in_ready, rdy);
    if (prev_vld && !s && !f) begin
      if (mret == 4'hF) saw_wrap = 1'b1;
      mret = mret + 4'd1;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("sig_out", sig_out, got.sig);
    chk("sig_valid", sig_valid, got.vld);
    chk("imm_out", imm_out, got.imm);
    chk("halted", halted, got.hlt);
    chk("illegal", illegal, got.ill);
    chk("retired", retired, mret);
    prev_vld = got.vld;
    cur = got;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{OP_NOT, S_NOT};   vt[1] = '{OP_INC, S_INC};
    vt[2] = '{OP_OUT, S_OUT};   vt[3] = '{OP_IN, S_IN};
    vt[4] = '{OP_NOP, S_NOP};   vt[5] = '{OP_SETC, S_SETC};
    vt[6] = '{OP_MOV, S_MOV};   vt[7] = '{OP_ADD, S_ADD};
    vt[8] = '{OP_SUB, S_SUB};   vt[9] = '{OP_AND, S_AND};

    reset = 1'b1; instr_word = '0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; resume = 1'b0;
    mret = '0; prev_vld = 1'b0; m_ill = 1'b0; saw_wrap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sig_out", sig_out, 0);
    chk("rst_sig_valid", sig_valid, 0);
    chk("rst_imm_out", imm_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    cur = mk('0, 1'b0, '0, 1'b0, 1'b0);

    // decode table, back to back
    for (int i = 0; i < 10; i++)
      apply(ow(vt[i].op), 1, 0, 0, 0, 1, mk(vt[i].sig, 1, cur.imm, 0, m_ill));
    apply(16'h0, 0, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));

    // two-word immediate, with idle cycles while waiting
    apply(ow(OP_IADD), 1, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(16'h1234, 0, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(16'h1234, 0, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(16'h00A5, 1, 0, 0, 0, 1, mk(S_IADD, 1, 16'h00A5, 0, m_ill));
    apply(ow(OP_IADD), 1, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(16'hC200, 1, 0, 0, 0, 1, mk(S_IADD, 1, 16'hC200, 0, m_ill));

    // halt with simultaneous resume, held 5 cycles, then resume
    apply(ow(OP_HLT), 1, 0, 0, 1, 1, mk(S_HLT, 1, cur.imm, 1, m_ill));
    for (int i = 0; i < 5; i++)
      apply(ow(OP_ADD), 1, 0, 0, 0, 0, mk(S_NOP, 0, cur.imm, 1, m_ill));
    apply(16'h0, 0, 0, 0, 1, 0, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(ow(OP_ADD), 1, 0, 0, 1, 1, mk(S_ADD, 1, cur.imm, 0, m_ill));

    // flush abandons IMM, discards a valid word, exits HALT
    apply(ow(OP_IADD), 1, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(ow(OP_NOT), 1, 0, 1, 0, 0, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(ow(OP_NOT), 1, 0, 0, 0, 1, mk(S_NOT, 1, cur.imm, 0, m_ill));
    apply(ow(OP_ADD), 1, 0, 1, 0, 0, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(ow(OP_HLT), 1, 0, 0, 0, 1, mk(S_HLT, 1, cur.imm, 1, m_ill));
    apply(16'h0, 0, 0, 1, 0, 0, mk(S_NOP, 0, cur.imm, 0, m_ill));

    // stall holds everything, retire happens once afterwards
    apply(ow(OP_ADD), 1, 0, 0, 0, 1, mk(S_ADD, 1, cur.imm, 0, m_ill));
    for (int i = 0; i < 3; i++)
      apply(ow(OP_SUB), 1, 1, 0, 0, 0, cur);
    apply(16'h0, 0, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));

    // illegal opcodes
    m_ill = TRAP;
    apply(ow(7'h7F), 1, 0, 0, 0, 1, mk(S_NOP, 1, cur.imm, TRAP, m_ill));
    apply(16'h0, 0, 0, 0, 1, !TRAP, mk(S_NOP, 0, cur.imm, 0, m_ill));
    apply(ow(7'h00), 1, 0, 0, 0, 1, mk(S_NOP, 1, cur.imm, TRAP, m_ill));
    apply(16'h0, 0, 0, 0, 1, !TRAP, mk(S_NOP, 0, cur.imm, 0, m_ill));

    // counter wrap on the 4-bit retired counter
    for (int i = 0; i < 20; i++)
      apply(ow(OP_ADD), 1, 0, 0, 0, 1, mk(S_ADD, 1, cur.imm, 0, m_ill));
    apply(16'h0, 0, 0, 0, 0, 1, mk(S_NOP, 0, cur.imm, 0, m_ill));
    chk("wrap_seen", saw_wrap, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
